// File: rtl/decode_msg.sv
// Kyber message decode: each message bit expands to one 12-bit-style coefficient,
// 0 for a clear bit and (q+1)/2 for a set bit, registered with one clock of latency.
module decode_msg #(
   parameter int KYBER_N       = 256,
   parameter int KYBER_R_WIDTH = 12,
   parameter int KYBER_Q       = 3329
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               in_valid,
   input  logic [KYBER_N-1:0]                 msg,
   output logic                               out_valid,
   output logic [KYBER_N*KYBER_R_WIDTH-1:0]   poly_msg
);

   localparam logic [KYBER_R_WIDTH-1:0] COEFF_ONE = KYBER_R_WIDTH'((KYBER_Q + 1) / 2);

   // Handshake: in_valid=1 on a rising edge captures msg; out_valid is high for
   // exactly the cycle after each capture. There is no ready, the block never stalls.
   logic [KYBER_N*KYBER_R_WIDTH-1:0] poly_msg_d, poly_msg_q;
   logic                             out_valid_d, out_valid_q;

   always_comb begin
      poly_msg_d  = poly_msg_q;
      out_valid_d = in_valid;
      if (in_valid) begin
         for (int i = 0; i < KYBER_N; i++) begin
            poly_msg_d[i*KYBER_R_WIDTH +: KYBER_R_WIDTH] = msg[i] ? COEFF_ONE : '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         poly_msg_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         poly_msg_q  <= poly_msg_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign poly_msg  = poly_msg_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_decode_msg.sv
// Self-checking bench for decode_msg: directed patterns, back-to-back, hold,
// asynchronous reset and randomized traffic against an arithmetic reference model.
module tb_decode_msg;

   localparam int N  = 256;
   localparam int W  = 12;
   localparam int PW = N * W;
   localparam int HALF_Q = (3329 + 1) / 2;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic [N-1:0]  msg;
   logic          out_valid;
   logic [PW-1:0] poly_msg;

   logic [PW-1:0] exp_q[$];
   logic [PW-1:0] exp_poly;
   logic          exp_valid;
   int            pass_cnt;
   int            total_cnt;

   decode_msg dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .msg       (msg),
      .out_valid (out_valid),
      .poly_msg  (poly_msg)
   );

   // clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: coefficient value = bit * round(q/2), placed at weight 2^(W*i)
   function automatic logic [PW-1:0] ref_poly(input logic [N-1:0] m);
      logic [PW-1:0] r;
      int            coeff;
      r = '0;
      for (int i = 0; i < N; i++) begin
         coeff = int'((m >> i) & 256'd1) * HALF_Q;
         r = r + (PW'(coeff) << (W * i));
      end
      return r;
   endfunction

   function automatic int first_diff(input logic [PW-1:0] a, input logic [PW-1:0] b);
      for (int i = 0; i < N; i++)
         if (a[i*W +: W] !== b[i*W +: W]) return i;
      return 0;
   endfunction

   function automatic logic [N-1:0] rand_msg();
      logic [N-1:0] m;
      for (int k = 0; k < N / 32; k++) m[k*32 +: 32] = $urandom;
      return m;
   endfunction

   // driver: set inputs and advance the model to what appears after the next edge
   task automatic drive(input logic v, input logic [N-1:0] m);
      in_valid = v;
      msg      = m;
      exp_valid = v;
      if (v) exp_poly = ref_poly(m);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, rand_msg());
         exp_poly = '0; exp_valid = 1'b0;
         @(negedge clk);
         total_cnt++;
         if (out_valid !== 1'b0 || poly_msg !== '0)
            $display("FAIL reset_%0d: out_valid=%b poly_nonzero=%b required 0/0", c, out_valid, |poly_msg);
         else pass_cnt++;
      end
      drive(1'b0, '0);
      exp_poly = '0;
      rst_n = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (out_valid !== 1'b0 || poly_msg !== '0)
         $display("FAIL reset_release: out_valid=%b poly_nonzero=%b required 0/0", out_valid, |poly_msg);
      else pass_cnt++;
   endtask

   task automatic test_patterns();
      logic [N-1:0] pats [4];
      int           idx;
      pats[0] = N'(12'h3FA);
      pats[1] = N'(12'h001);
      pats[2] = N'(12'h1B4);
      pats[3] = '1;
      for (int p = 0; p < 4; p++) begin
         drive(1'b1, pats[p]);
         @(negedge clk);
         total_cnt++;
         if (out_valid !== 1'b1) $display("FAIL pattern_%0d_valid: got %b required 1", p, out_valid);
         else pass_cnt++;
         total_cnt++;
         idx = first_diff(poly_msg, exp_poly);
         if (poly_msg !== exp_poly)
            $display("FAIL pattern_%0d_poly: coeff[%0d] got %h required %h", p, idx,
                     poly_msg[idx*W +: W], exp_poly[idx*W +: W]);
         else pass_cnt++;
      end
      // spot checks of individual fields against literal 0x681 / 0
      total_cnt++;
      if (poly_msg[255*W +: W] !== 12'h681 || poly_msg[0 +: W] !== 12'h681)
         $display("FAIL all_ones_ends: coeff0=%h coeff255=%h required 681/681", poly_msg[0 +: W], poly_msg[255*W +: W]);
      else pass_cnt++;
      drive(1'b1, N'(12'h3FA));
      @(negedge clk);
      total_cnt++;
      if (poly_msg[0 +: W] !== 12'h000 || poly_msg[1*W +: W] !== 12'h681 ||
          poly_msg[9*W +: W] !== 12'h681 || poly_msg[10*W +: W] !== 12'h000)
         $display("FAIL 3fa_fields: c0=%h c1=%h c9=%h c10=%h required 000/681/681/000",
                  poly_msg[0 +: W], poly_msg[1*W +: W], poly_msg[9*W +: W], poly_msg[10*W +: W]);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] seq [3];
      logic [PW-1:0] want;
      int            idx;
      seq[0] = N'(12'h3FA);
      seq[1] = N'(12'h001);
      seq[2] = N'(12'h1B4);
      for (int k = 0; k < 4; k++) begin
         if (k < 3) begin
            drive(1'b1, seq[k]);
            exp_q.push_back(exp_poly);
         end else begin
            drive(1'b0, rand_msg());
         end
         @(negedge clk);
         if (k < 3) begin
            want = exp_q.pop_front();
            total_cnt++;
            idx = first_diff(poly_msg, want);
            if (out_valid !== 1'b1 || poly_msg !== want)
               $display("FAIL b2b_%0d: valid=%b coeff[%0d] got %h required %h", k, out_valid, idx,
                        poly_msg[idx*W +: W], want[idx*W +: W]);
            else pass_cnt++;
         end else begin
            total_cnt++;
            if (out_valid !== 1'b0 || poly_msg !== ref_poly(seq[2]))
               $display("FAIL b2b_hold: valid=%b poly_held=%b required 0/1", out_valid, poly_msg === ref_poly(seq[2]));
            else pass_cnt++;
         end
      end
      // msg toggling with in_valid low must not reach the output
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, rand_msg());
         @(negedge clk);
         total_cnt++;
         if (out_valid !== 1'b0 || poly_msg !== ref_poly(seq[2]))
            $display("FAIL idle_ignore_%0d: valid=%b poly_held=%b required 0/1", k, out_valid, poly_msg === ref_poly(seq[2]));
         else pass_cnt++;
      end
   endtask

   task automatic test_random();
      int idx;
      for (int c = 0; c < 60; c++) begin
         drive(1'($urandom_range(0, 1)), rand_msg());
         @(negedge clk);
         total_cnt++;
         idx = first_diff(poly_msg, exp_poly);
         if (out_valid !== exp_valid || poly_msg !== exp_poly)
            $display("FAIL random_%0d: valid=%b (req %b) coeff[%0d] got %h required %h", c, out_valid,
                     exp_valid, idx, poly_msg[idx*W +: W], exp_poly[idx*W +: W]);
         else pass_cnt++;
      end
   endtask

   task automatic test_async_reset();
      drive(1'b1, rand_msg());
      @(posedge clk);
      #2;
      total_cnt++;
      if (out_valid !== 1'b1 || poly_msg !== exp_poly)
         $display("FAIL async_pre: valid=%b poly_ok=%b required 1/1", out_valid, poly_msg === exp_poly);
      else pass_cnt++;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if (out_valid !== 1'b0 || poly_msg !== '0)
         $display("FAIL async_clear: valid=%b poly_nonzero=%b required 0/0", out_valid, |poly_msg);
      else pass_cnt++;
      @(negedge clk);
      drive(1'b0, '0);
      exp_poly = '0;
      rst_n = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (out_valid !== 1'b0 || poly_msg !== '0)
         $display("FAIL async_after: valid=%b poly_nonzero=%b required 0/0", out_valid, |poly_msg);
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      exp_poly  = '0;
      exp_valid = 1'b0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      msg       = '0;
      @(negedge clk);
      test_reset();
      test_patterns();
      test_back_to_back();
      test_random();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
